// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer
//   Stereo I2S / left-justified transmitter for the codec DAC pin. Derives
//   LRCLK from BCLK, buffers one stereo pair behind a VALID/READY handshake and
//   shifts the current frame out MSB-first on AUD_OUT.
//
// Parameters
//   DATA_WIDTH     bits per channel sample (4..32)
//   SLOT_WIDTH     BCLK cycles per channel slot (>= DATA_WIDTH + justify delay)
//   JUSTIFY        0 = I2S (MSB one BCLK after LRCLK edge), 1 = left-justified
//   UNDERRUN_ZERO  1 = send zeros when starved, 0 = repeat the previous frame
//
// Ports
//   BCLK           in   bit clock, all logic on its rising edge
//   RST_N          in   asynchronous active-low reset
//   LEFT_CHANNEL   in   left sample, two's complement
//   RIGHT_CHANNEL  in   right sample, two's complement
//   SAMPLE_VALID   in   LEFT/RIGHT_CHANNEL hold a new stereo pair
//   SAMPLE_READY   out  holding register empty; pair taken on VALID && READY
//   LRCLK          out  0 = left slot, 1 = right slot
//   AUD_OUT        out  serial audio data
//   UNDERRUN       out  one-cycle pulse when a frame starts with no sample
module i2s_tx_framer #(
  parameter int DATA_WIDTH    = 16,
  parameter int SLOT_WIDTH    = 32,
  parameter int JUSTIFY       = 0,
  parameter int UNDERRUN_ZERO = 1
) (
  input  logic                         BCLK,
  input  logic                         RST_N,
  input  logic signed [DATA_WIDTH-1:0] LEFT_CHANNEL,
  input  logic signed [DATA_WIDTH-1:0] RIGHT_CHANNEL,
  input  logic                         SAMPLE_VALID,
  output logic                         SAMPLE_READY,
  output logic                         LRCLK,
  output logic                         AUD_OUT,
  output logic                         UNDERRUN
);

  localparam int JDELAY    = (JUSTIFY == 0) ? 1 : 0;
  localparam int FRAME_LEN = 2 * SLOT_WIDTH;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] JD_C   = CW'(JDELAY);

  // cyc is the frame cycle the next rising edge will present on the outputs.
  logic [CW-1:0]                cyc;
  logic                         first_frame;
  logic                         hold_full;
  logic signed [DATA_WIDTH-1:0] hold_l, hold_r;
  logic signed [DATA_WIDTH-1:0] frame_l, frame_r;

  logic                         load_edge, bypass, starve, accept;
  logic                         hold_full_nxt;
  logic signed [DATA_WIDTH-1:0] frame_l_nxt, frame_r_nxt;
  logic                         right_slot, lead_ok, in_range, aud_nxt;
  logic [CW-1:0]                slot_pos, bit_pos;
  logic signed [DATA_WIDTH-1:0] chan;
  logic [DATA_WIDTH-1:0]        shifted;

  // ---- load / handshake decisions for the coming edge ----
  always_comb begin
    load_edge     = (cyc == '0) && !first_frame;
    bypass        = load_edge && !hold_full && SAMPLE_VALID;
    starve        = load_edge && !hold_full && !SAMPLE_VALID;
    accept        = SAMPLE_VALID && !hold_full && !bypass;
    frame_l_nxt   = frame_l;
    frame_r_nxt   = frame_r;
    hold_full_nxt = hold_full;
    if (load_edge) begin
      if (hold_full) begin
        frame_l_nxt   = hold_l;
        frame_r_nxt   = hold_r;
        hold_full_nxt = 1'b0;
      end else if (SAMPLE_VALID) begin
        frame_l_nxt = LEFT_CHANNEL;
        frame_r_nxt = RIGHT_CHANNEL;
      end else if (UNDERRUN_ZERO != 0) begin
        frame_l_nxt = '0;
        frame_r_nxt = '0;
      end
    end
    if (accept) hold_full_nxt = 1'b1;
  end

  // ---- serial bit selection for the coming edge ----
  // Uses the post-load frame value so left-justified mode can put the new
  // MSB out on the very edge that loads it.
  always_comb begin
    right_slot = (cyc >= SLOT_C);
    slot_pos   = right_slot ? (cyc - SLOT_C) : cyc;
    bit_pos    = slot_pos - JD_C;
    lead_ok    = (JDELAY == 0) || (slot_pos != '0);
    in_range   = lead_ok && (bit_pos < DW_C);
    chan       = right_slot ? frame_r_nxt : frame_l_nxt;
    shifted    = chan << bit_pos;
    aud_nxt    = in_range && shifted[DATA_WIDTH-1];
  end

  // ---- registered state and outputs ----
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc         <= '0;
      first_frame <= 1'b1;
      hold_full   <= 1'b0;
      frame_l     <= '0;
      frame_r     <= '0;
      LRCLK       <= 1'b1;
      AUD_OUT     <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      cyc         <= (cyc == LAST_C) ? '0 : cyc + CW'(1);
      if (cyc == LAST_C) first_frame <= 1'b0;
      hold_full   <= hold_full_nxt;
      frame_l     <= frame_l_nxt;
      frame_r     <= frame_r_nxt;
      LRCLK       <= right_slot;
      AUD_OUT     <= aud_nxt;
      UNDERRUN    <= starve;
    end
  end

  // Holding data needs no reset: it is only ever read while hold_full is set.
  always_ff @(posedge BCLK) begin
    if (accept) begin
      hold_l <= LEFT_CHANNEL;
      hold_r <= RIGHT_CHANNEL;
    end
  end

  assign SAMPLE_READY = !hold_full;

endmodule

// File: tb/tb_i2s_tx_framer.sv
module tb_i2s_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] left = '0, right = '0;
  logic        valid = 1'b0;

  logic ready0, lr0, aud0, und0;
  logic ready1, lr1, aud1, und1;
  logic ready2, lr2, aud2, und2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // I2S, zero on underrun
  i2s_tx_framer #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .JUSTIFY(0), .UNDERRUN_ZERO(1)) dut0 (
    .BCLK(clk), .RST_N(rst_n), .LEFT_CHANNEL(left), .RIGHT_CHANNEL(right),
    .SAMPLE_VALID(valid), .SAMPLE_READY(ready0), .LRCLK(lr0), .AUD_OUT(aud0), .UNDERRUN(und0));
  // left-justified, zero on underrun
  i2s_tx_framer #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .JUSTIFY(1), .UNDERRUN_ZERO(1)) dut1 (
    .BCLK(clk), .RST_N(rst_n), .LEFT_CHANNEL(left), .RIGHT_CHANNEL(right),
    .SAMPLE_VALID(valid), .SAMPLE_READY(ready1), .LRCLK(lr1), .AUD_OUT(aud1), .UNDERRUN(und1));
  // I2S, repeat previous frame on underrun
  i2s_tx_framer #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .JUSTIFY(0), .UNDERRUN_ZERO(0)) dut2 (
    .BCLK(clk), .RST_N(rst_n), .LEFT_CHANNEL(left), .RIGHT_CHANNEL(right),
    .SAMPLE_VALID(valid), .SAMPLE_READY(ready2), .LRCLK(lr2), .AUD_OUT(aud2), .UNDERRUN(und2));

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        und;
    logic [15:0] l2;
    logic [15:0] r2;
  } exp_t;
  exp_t expq[$];

  // Bench-side frame timing: pres_c is the cycle shown after the last edge.
  int pres_c = -1, pres_frame = -1, tb_next_c = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_c     <= -1;
      pres_frame <= -1;
      tb_next_c  <= 0;
    end else begin
      pres_c    <= tb_next_c;
      tb_next_c <= (tb_next_c == 63) ? 0 : tb_next_c + 1;
      if (tb_next_c == 0) pres_frame <= pres_frame + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pat(input logic [15:0] l, input logic [15:0] r, input bit lj);
    if (lj) return {l, 16'h0000, r, 16'h0000};
    return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic u,
                      input logic [15:0] l2, input logic [15:0] r2);
    exp_t e;
    e.l = l; e.r = r; e.und = u; e.l2 = l2; e.r2 = r2;
    expq.push_back(e);
  endtask

  // Return at the falling edge just before the edge that presents (f, c).
  task automatic wait_at(input int f, input int c);
    int n;
    int nf;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      nf = (tb_next_c == 0) ? pres_frame + 1 : pres_frame;
      if (tb_next_c == c && nf == f) break;
      if (n > 20000) begin
        errors++;
        $display("FAIL wait_at frame %0d cycle %0d: not reached", f, c);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
      end
    end
  endtask

  // Monitor: collect one frame of serial data per DUT, then score it.
  initial begin : monitor
    logic [63:0] cap0, cap1, cap2;
    logic        und_first, und_extra, lr_bad;
    exp_t        e;
    cap0 = '0; cap1 = '0; cap2 = '0;
    und_first = 1'b0; und_extra = 1'b0; lr_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || pres_c < 0) continue;
      if (pres_c == 0) begin
        cap0 = '0; cap1 = '0; cap2 = '0;
        und_first = und0;
        und_extra = (und1 != und0) || (und2 != und0);
        lr_bad    = 1'b0;
      end else begin
        und_extra = und_extra | und0 | und1 | und2;
      end
      cap0[63 - pres_c] = aud0;
      cap1[63 - pres_c] = aud1;
      cap2[63 - pres_c] = aud2;
      if (lr0 !== (pres_c >= 32) || lr1 !== (pres_c >= 32) || lr2 !== (pres_c >= 32))
        lr_bad = 1'b1;
      if (pres_c == 63) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame %0d: no expectation queued", pres_frame);
        end else begin
          e = expq.pop_front();
          chk($sformatf("i2s_data f%0d", pres_frame), cap0, pat(e.l, e.r, 1'b0));
          chk($sformatf("lj_data f%0d", pres_frame), cap1, pat(e.l, e.r, 1'b1));
          chk($sformatf("repeat_data f%0d", pres_frame), cap2, pat(e.l2, e.r2, 1'b0));
          chk($sformatf("underrun f%0d", pres_frame), 64'(und_first), 64'(e.und));
          chk($sformatf("underrun_extra f%0d", pres_frame), 64'(und_extra), 64'd0);
          chk($sformatf("lrclk f%0d", pres_frame), 64'(lr_bad), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] dl [3];
    logic [15:0] dr [3];
    int          k;
    int          n;
    logic        take;
    dl[0] = 16'h1230; dl[1] = 16'h1231; dl[2] = 16'h1232;
    dr[0] = 16'hFED0; dr[1] = 16'hFECF; dr[2] = 16'hFECE;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("reset_lrclk", 64'(lr0), 64'd1);
    chk("reset_aud", 64'(aud0), 64'd0);
    chk("reset_ready", 64'(ready0), 64'd1);
    chk("reset_underrun", 64'(und0), 64'd0);

    // Frame 0 zeros, frame 1 carries A, frames 2..3 starve
    push(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    push(16'hA5C3, 16'h8001, 1'b0, 16'hA5C3, 16'h8001);
    push(16'h0000, 16'h0000, 1'b1, 16'hA5C3, 16'h8001);
    push(16'h0000, 16'h0000, 1'b1, 16'hA5C3, 16'h8001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wait_at(0, 10);
    chk("ready_before_accept", 64'(ready0), 64'd1);
    valid = 1'b1; left = 16'hA5C3; right = 16'h8001;
    wait_at(0, 11);
    valid = 1'b0;
    chk("ready_after_accept", 64'(ready0), 64'd0);
    wait_at(1, 1);
    chk("ready_after_load", 64'(ready0), 64'd1);

    // Back-to-back stream: one pair per frame in frames 4..6
    push(dl[0], dr[0], 1'b0, dl[0], dr[0]);
    push(dl[1], dr[1], 1'b0, dl[1], dr[1]);
    push(dl[2], dr[2], 1'b0, dl[2], dr[2]);
    wait_at(3, 20);
    k = 0;
    valid = 1'b1; left = dl[0]; right = dr[0];
    take = ready0;
    n = 0;
    while (k < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (take) begin
        k++;
        if (k == 1) chk("ready_low_b2b", 64'(ready0), 64'd0);
        if (k < 3) begin
          left = dl[k]; right = dr[k];
        end else begin
          valid = 1'b0;
        end
      end
      take = ready0 && valid;
    end
    chk("b2b_pairs_taken", 64'(k), 64'd3);
    valid = 1'b0;

    // Bypass on the load edge of frame 7, then starve in frame 8
    push(16'h7FFF, 16'h0F0F, 1'b0, 16'h7FFF, 16'h0F0F);
    push(16'h0000, 16'h0000, 1'b1, 16'h7FFF, 16'h0F0F);
    wait_at(7, 0);
    chk("ready_before_bypass", 64'(ready0), 64'd1);
    valid = 1'b1; left = 16'h7FFF; right = 16'h0F0F;
    wait_at(7, 1);
    valid = 1'b0;
    chk("ready_after_bypass", 64'(ready0), 64'd1);

    // P loads into frame 9, Q sits in holding, reset lands at c=40
    wait_at(8, 10);
    valid = 1'b1; left = 16'h1357; right = 16'h2589;
    wait_at(8, 11);
    valid = 1'b0;
    wait_at(9, 5);
    valid = 1'b1; left = 16'hABCD; right = 16'hDCBA;
    wait_at(9, 6);
    valid = 1'b0;
    wait_at(9, 41);
    chk("pre_reset_aud", 64'(aud0), 64'd1);
    chk("pre_reset_aud_lj", 64'(aud1), 64'd1);
    chk("pre_reset_ready", 64'(ready0), 64'd0);
    push(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    push(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_lrclk", 64'(lr0), 64'd1);
    chk("midreset_aud", 64'(aud0), 64'd0);
    chk("midreset_aud_lj", 64'(aud1), 64'd0);
    chk("midreset_ready", 64'(ready0), 64'd1);
    chk("midreset_underrun", 64'(und0), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wait_at(2, 1);
    chk("expectations_left", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
